// File: rtl/dma_burst_addr_gen.sv
// dma_burst_addr_gen: turns one DMA descriptor into a stream of src/dst address
// pairs, one per accepted beat, over a valid/ready handshake.
// Optional feature: define DMA_ADDR_GEN_ABORT_EN to add the abort_i port.
module dma_burst_addr_gen #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned BEAT_BYTES = 4
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_base_i,
    input  logic [ADDR_WIDTH-1:0] dst_base_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    input  logic                  src_fixed_i,
    input  logic                  dst_fixed_i,
`ifdef DMA_ADDR_GEN_ABORT_EN
    input  logic                  abort_i,
`endif
    output logic                  addr_valid_o,
    input  logic                  addr_ready_i,
    output logic [ADDR_WIDTH-1:0] src_addr_o,
    output logic [ADDR_WIDTH-1:0] dst_addr_o,
    output logic                  last_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(BEAT_BYTES);
    localparam logic [LEN_WIDTH-1:0]  ONE  = LEN_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GEN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                state_q;
    logic [LEN_WIDTH-1:0]  remaining_q;
    logic                  src_fixed_q;
    logic                  dst_fixed_q;
    logic                  handshake_c;
    logic                  abort_c;
    logic [ADDR_WIDTH-1:0] src_next_c;
    logic [ADDR_WIDTH-1:0] dst_next_c;
    logic [LEN_WIDTH-1:0]  remaining_dec_c;

`ifdef DMA_ADDR_GEN_ABORT_EN
    assign abort_c = abort_i;
`else
    assign abort_c = 1'b0;
`endif

    // Per-beat next values; address arithmetic wraps modulo 2^ADDR_WIDTH.
    assign handshake_c     = addr_valid_o && addr_ready_i;
    assign src_next_c      = src_fixed_q ? src_addr_o : src_addr_o + STEP;
    assign dst_next_c      = dst_fixed_q ? dst_addr_o : dst_addr_o + STEP;
    assign remaining_dec_c = remaining_q - ONE;

    // Burst FSM with all outputs registered.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            remaining_q  <= '0;
            src_fixed_q  <= 1'b0;
            dst_fixed_q  <= 1'b0;
            addr_valid_o <= 1'b0;
            src_addr_o   <= '0;
            dst_addr_o   <= '0;
            last_o       <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    addr_valid_o <= 1'b0;
                    done_o       <= 1'b0;
                    busy_o       <= 1'b0;
                    if (start_i) begin
                        busy_o      <= 1'b1;
                        src_fixed_q <= src_fixed_i;
                        dst_fixed_q <= dst_fixed_i;
                        if (len_i != '0) begin
                            state_q      <= ST_GEN;
                            addr_valid_o <= 1'b1;
                            src_addr_o   <= src_base_i;
                            dst_addr_o   <= dst_base_i;
                            remaining_q  <= len_i;
                            last_o       <= (len_i == ONE);
                        end else begin
                            // Empty descriptor: complete without issuing beats.
                            state_q     <= ST_DONE;
                            remaining_q <= '0;
                            done_o      <= 1'b1;
                        end
                    end
                end
                ST_GEN: begin
                    if (handshake_c) begin
                        src_addr_o  <= src_next_c;
                        dst_addr_o  <= dst_next_c;
                        remaining_q <= remaining_dec_c;
                        last_o      <= (remaining_dec_c == ONE);
                        if (remaining_q == ONE) begin
                            state_q      <= ST_DONE;
                            addr_valid_o <= 1'b0;
                            done_o       <= 1'b1;
                        end
                    end
                    // Abort wins over continuation; a coincident beat still counts.
                    if (abort_c) begin
                        state_q      <= ST_DONE;
                        addr_valid_o <= 1'b0;
                        last_o       <= 1'b0;
                        remaining_q  <= '0;
                        done_o       <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    done_o  <= 1'b0;
                    busy_o  <= 1'b0;
                end
                default: begin
                    state_q      <= ST_IDLE;
                    addr_valid_o <= 1'b0;
                    done_o       <= 1'b0;
                    busy_o       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dma_burst_addr_gen.sv
// Testbench for dma_burst_addr_gen: scenario tasks with randomized stimulus
// checked against an arithmetic reference of the expected address sequence.
module tb_dma_burst_addr_gen;

    localparam int unsigned AW = 16;
    localparam int unsigned LW = 8;
    localparam int unsigned BEAT_BYTES = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [LW-1:0] len_in = '0;
    logic          src_fixed = 1'b0;
    logic          dst_fixed = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b0;
    logic          valid;
    logic [AW-1:0] src_addr;
    logic [AW-1:0] dst_addr;
    logic          last;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    dma_burst_addr_gen #(
        .ADDR_WIDTH(AW),
        .LEN_WIDTH (LW),
        .BEAT_BYTES(BEAT_BYTES)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .src_base_i  (src_base),
        .dst_base_i  (dst_base),
        .len_i       (len_in),
        .src_fixed_i (src_fixed),
        .dst_fixed_i (dst_fixed),
`ifdef DMA_ADDR_GEN_ABORT_EN
        .abort_i     (abort),
`endif
        .addr_valid_o(valid),
        .addr_ready_i(ready),
        .src_addr_o  (src_addr),
        .dst_addr_o  (dst_addr),
        .last_o      (last),
        .busy_o      (busy),
        .done_o      (done)
    );

    always #5 clk = ~clk;

    // Reference: expected address of beat n for a side with given base/mode.
    function automatic logic [AW-1:0] ref_addr(input logic [AW-1:0] base, input bit fixed, input int n);
        return fixed ? base : base + AW'(n * BEAT_BYTES);
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++; if (src_addr !== '0) begin errors++; $display("FAIL reset_src got=%h exp=0000", src_addr); end
        checks++; if (dst_addr !== '0) begin errors++; $display("FAIL reset_dst got=%h exp=0000", dst_addr); end
        checks++; if (last !== 1'b0) begin errors++; $display("FAIL reset_last got=%b exp=0", last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        reset = 1'b0;
    endtask

    // Drives one descriptor and checks every cycle until back in IDLE.
    // rmode: 0 = ready always 1, 1 = random ready, 2 = ready from pat[cycle].
    task automatic run_burst(input logic [AW-1:0] sb, input logic [AW-1:0] db, input int len,
                             input bit sf, input bit df, input int rmode,
                             input logic [31:0] pat, input bit inject, input string tag);
        int beat = 0;
        int cyc = 0;
        logic rdy;
        logic [AW-1:0] es, ed;
        @(negedge clk);
        src_base = sb; dst_base = db; len_in = LW'(len);
        src_fixed = sf; dst_fixed = df; start = 1'b1; ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        while (beat < len && cyc < 200) begin
            es = ref_addr(sb, sf, beat);
            ed = ref_addr(db, df, beat);
            checks++; if (valid !== 1'b1) begin errors++; $display("FAIL %s valid beat%0d got=%b exp=1", tag, beat, valid); end
            checks++; if (src_addr !== es) begin errors++; $display("FAIL %s src beat%0d got=%h exp=%h", tag, beat, src_addr, es); end
            checks++; if (dst_addr !== ed) begin errors++; $display("FAIL %s dst beat%0d got=%h exp=%h", tag, beat, dst_addr, ed); end
            checks++; if (last !== (beat == len - 1)) begin errors++; $display("FAIL %s last beat%0d got=%b exp=%b", tag, beat, last, beat == len - 1); end
            checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL %s busy/done beat%0d got=%b/%b exp=1/0", tag, beat, busy, done); end
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 1) == 1);
                default: rdy = (cyc < 32) ? pat[cyc] : 1'b1;
            endcase
            ready = rdy;
            if (inject && cyc == 1) begin
                start = 1'b1; src_base = ~sb; dst_base = ~db; len_in = LW'(7);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (rdy) beat++;
            cyc++;
        end
        start = 1'b0;
        ready = 1'b0;
        if (beat < len) begin
            checks++; errors++; $display("FAIL %s timeout beats got=%0d exp=%0d", tag, beat, len);
        end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL %s end_valid got=%b exp=0", tag, valid); end
        checks++; if (done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL %s done_pulse got=%b/%b exp=1/1", tag, done, busy); end
        @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL %s idle done/busy/valid got=%b/%b/%b exp=0/0/0", tag, done, busy, valid);
        end
    endtask

    task automatic test_incr();
        run_burst(16'h1000, 16'h2000, 4, 1'b0, 1'b0, 0, 32'h0, 1'b0, "incr");
    endtask

    task automatic test_fixed();
        run_burst(16'h0040, 16'h0100, 3, 1'b1, 1'b0, 0, 32'h0, 1'b0, "fixed_src");
        run_burst(16'h0300, 16'h0500, 3, 1'b0, 1'b1, 0, 32'h0, 1'b0, "fixed_dst");
    endtask

    task automatic test_backpressure();
        run_burst(16'h0A00, 16'h0B00, 2, 1'b0, 1'b0, 2, 32'b10100, 1'b0, "ready_pat");
    endtask

    task automatic test_wrap();
        run_burst(16'hFFFC, 16'hFFF8, 3, 1'b0, 1'b0, 0, 32'h0, 1'b0, "wrap");
    endtask

    task automatic test_len_zero();
        run_burst(16'h1234, 16'h5678, 0, 1'b0, 1'b0, 0, 32'h0, 1'b0, "len0");
    endtask

    task automatic test_start_ignored();
        run_burst(16'h0800, 16'h0900, 4, 1'b0, 1'b0, 0, 32'h0, 1'b1, "start_busy");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            run_burst(AW'($urandom), AW'($urandom), int'($urandom_range(0, 9)),
                      bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                      1, 32'h0, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid_burst();
        @(negedge clk);
        src_base = 16'h4000; dst_base = 16'h6000; len_in = LW'(5);
        src_fixed = 1'b0; dst_fixed = 1'b0; start = 1'b1; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checks++; if (valid !== 1'b1 || src_addr !== 16'h4008) begin
            errors++; $display("FAIL rst_mid pre valid/src got=%b/%h exp=1/4008", valid, src_addr);
        end
        ready = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        checks++; if (valid !== 1'b0 || src_addr !== '0 || dst_addr !== '0 || last !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rst_mid outputs got=%b/%h/%h/%b/%b/%b exp=all zero", valid, src_addr, dst_addr, last, busy, done);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            checks++; if (done !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
                errors++; $display("FAIL rst_mid after%0d done/valid/busy got=%b/%b/%b exp=0/0/0", k, done, valid, busy);
            end
        end
    endtask

`ifdef DMA_ADDR_GEN_ABORT_EN
    task automatic test_abort();
        @(negedge clk);
        src_base = 16'h7000; dst_base = 16'h7100; len_in = LW'(5);
        src_fixed = 1'b0; dst_fixed = 1'b0; start = 1'b1; ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if (valid !== 1'b1 || src_addr !== 16'h7004) begin
            errors++; $display("FAIL abort beat2 valid/src got=%b/%h exp=1/7004", valid, src_addr);
        end
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        ready = 1'b0;
        checks++; if (valid !== 1'b0 || done !== 1'b1) begin
            errors++; $display("FAIL abort drop valid/done got=%b/%b exp=0/1", valid, done);
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL abort single_pulse done/busy got=%b/%b exp=0/0", done, busy);
        end
        @(posedge clk);
        @(negedge clk);
        checks++; if (done !== 1'b0 || valid !== 1'b0) begin
            errors++; $display("FAIL abort idle done/valid got=%b/%b exp=0/0", done, valid);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_incr();
        test_fixed();
        test_backpressure();
        test_wrap();
        test_len_zero();
        test_start_ignored();
        test_random();
        test_reset_mid_burst();
`ifdef DMA_ADDR_GEN_ABORT_EN
        test_abort();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_burst_addr_gen.md
Name: dma_burst_addr_gen

Overview:
- Parametrised successor to the DMA single-shot address generator.
- Takes one descriptor (src base, dst base, beat count, per-side mode) and emits a stream of src/dst address pairs, one per accepted beat.
- Output stream uses a valid/ready handshake.
- Sits between the descriptor fetch logic and the DMA read/write engines.

Parameters:
- ADDR_WIDTH, 16, width of all address buses.
- LEN_WIDTH, 8, width of the beat-count field; max burst is 2^LEN_WIDTH-1 beats.
- BEAT_BYTES, 4, address increment per beat in INCR mode; power of two, 1..64.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- reset_i  in  1  synchronous, active-high reset.
- start_i  in  1  descriptor valid; sampled only in IDLE.
- src_base_i  in  ADDR_WIDTH  source start address.
- dst_base_i  in  ADDR_WIDTH  destination start address.
- len_i  in  LEN_WIDTH  number of beats.
- src_fixed_i  in  1  1 = source address constant (FIXED), 0 = INCR.
- dst_fixed_i  in  1  1 = destination address constant (FIXED), 0 = INCR.
- addr_valid_o  out  1  current address pair valid.
- addr_ready_i  in  1  consumer accepts the pair when valid and ready are both high.
- src_addr_o  out  ADDR_WIDTH  current source address.
- dst_addr_o  out  ADDR_WIDTH  current destination address.
- last_o  out  1  current pair is the final beat; qualified by addr_valid_o.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: single clock clk_i; reset_i is synchronous, active-high.
- Reset values: state=IDLE; addr_valid_o=0, src_addr_o=0, dst_addr_o=0, last_o=0, busy_o=0, done_o=0; internal beat counter=0.
- States: IDLE, GEN, DONE.
- IDLE, start_i=1, len_i!=0:
  - Latch bases, len_i and modes.
  - Next cycle: state=GEN, addr_valid_o=1, src/dst_addr_o=bases, remaining=len_i.
  - Latency from start_i to first valid is 1 cycle.
- IDLE, start_i=1, len_i==0: go to DONE; no beats issued.
- IDLE, start_i=0: stay in IDLE; outputs hold their last values, addr_valid_o=0.
- GEN, addr_valid_o && addr_ready_i (handshake):
  - remaining decrements by 1.
  - Each INCR side advances by BEAT_BYTES; each FIXED side holds.
  - If remaining was 1: addr_valid_o=0 next cycle, state=DONE.
- GEN, valid && !ready: src_addr_o, dst_addr_o and last_o hold stable; addr_valid_o must not drop.
- last_o = (remaining==1) while in GEN.
- Beats may be accepted back-to-back, one per cycle, with no bubbles.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o deasserts on the IDLE cycle.
- Address arithmetic: unsigned, modulo 2^ADDR_WIDTH. Wrap past all-ones to 0 silently; no error flag.
- start_i while busy_o=1: ignored; the descriptor is not queued.
- reset_i asserted mid-burst: on the next edge all outputs take reset values; the burst is abandoned; no done_o pulse.

Optional Feature:
- Macro: DMA_ADDR_GEN_ABORT_EN
- Defined:
  - Adds port abort_i (in, 1).
  - abort_i=1 in GEN forces DONE on the next edge: addr_valid_o=0, remaining beats discarded, done_o pulses once.
  - If abort_i coincides with a handshake, that beat counts as accepted; the abort still takes effect.
  - abort_i in IDLE or DONE is ignored.
- Not defined: no abort_i port; a burst always runs to completion or reset.

Test Plan:
- Reset, then start_i with src=0x1000, dst=0x2000, len=4, both INCR, ready held 1 -> src 0x1000/04/08/0C and dst 0x2000/04/08/0C on consecutive cycles; last_o on the 4th pair; done_o one cycle after the 4th handshake.
- src_fixed=1, dst INCR, len=3, src=0x0040, dst=0x0100 -> src stays 0x0040; dst 0x0100/0x0104/0x0108.
- len=2, ready toggled 0,0,1,0,1 -> each pair held stable while ready=0; exactly 2 handshakes; done_o follows the second.
- src=0xFFFC, BEAT_BYTES=4, len=3 -> src 0xFFFC/0x0000/0x0004 (wrap, no flag).
- len=0 -> no addr_valid_o; done_o one cycle after the start cycle. Separately: start_i pulsed mid-burst -> ignored, burst unchanged.
- reset_i asserted after the 2nd of 5 beats -> all outputs 0 next cycle, no done_o. With DMA_ADDR_GEN_ABORT_EN: abort_i on beat 2 of 5 -> valid drops, single done_o.
